// File: rtl/cpu_pkg.sv
// Shared definitions for the decode/execute datapath: control-word layout,
// the PC register address and the operand forward-select encoding.
package cpu_pkg;

  localparam logic [3:0]  R15    = 4'hF;
  localparam int unsigned CTRL_W = 12;

  localparam int unsigned CTRL_REGWRITE  = 11;
  localparam int unsigned CTRL_MEMWRITE  = 10;
  localparam int unsigned CTRL_MEMTOREG  = 9;
  localparam int unsigned CTRL_BRANCH    = 8;
  localparam int unsigned CTRL_ALUSRC    = 7;
  localparam int unsigned CTRL_FLAGW_HI  = 6;
  localparam int unsigned CTRL_FLAGW_LO  = 5;
  localparam int unsigned CTRL_ALUCTL_HI = 4;
  localparam int unsigned CTRL_ALUCTL_LO = 3;
  localparam int unsigned CTRL_PCSRC     = 2;
  localparam int unsigned CTRL_COND_EN   = 1;
  localparam int unsigned CTRL_SHIFT     = 0;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_t;

endpackage

// File: rtl/de_pipe_stage_fwd_sel.sv
// Forward-select for one E-stage source address against the M and W writers.
// M wins over W; R15 and invalid E slots always read the registered value.
module fwd_sel
  import cpu_pkg::*;
#(
  parameter int unsigned AW = 4
) (
  input  logic [AW-1:0] i_ra,
  input  logic          i_valid,
  input  logic          i_regwrite_m,
  input  logic [AW-1:0] i_wa3_m,
  input  logic          i_we3_w,
  input  logic [AW-1:0] i_wa3_w,
  output fwd_t          o_sel
);

  logic w_fwd_ok;
  logic w_hit_m;
  logic w_hit_w;

  assign w_fwd_ok = i_valid && (i_ra != AW'(R15));
  assign w_hit_m  = i_regwrite_m && (i_wa3_m == i_ra);
  assign w_hit_w  = i_we3_w && (i_wa3_w == i_ra);

  always_comb begin
    o_sel = FWD_RF;
    if (w_fwd_ok && w_hit_m) begin
      o_sel = FWD_M;
    end else if (w_fwd_ok && w_hit_w) begin
      o_sel = FWD_W;
    end
  end

endmodule

// File: rtl/de_pipe_stage.sv
// Decode-to-execute pipeline register with same-cycle W bypass on capture,
// M/W operand forwarding in E, and load-use hazard detection.
module de_pipe_stage
  import cpu_pkg::*;
#(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AW-1:0]     ra1_d,
  input  logic [AW-1:0]     ra2_d,
  input  logic [DW-1:0]     rd1_d,
  input  logic [DW-1:0]     rd2_d,
  input  logic [AW-1:0]     wa3_d,
  input  logic [DW-1:0]     extimm_d,
  input  logic [CTRL_W-1:0] ctrl_d,
  input  logic [3:0]        cond_d,
  input  logic              stall_e,
  input  logic              flush_e,
  input  logic              we3_w,
  input  logic [AW-1:0]     wa3_w,
  input  logic [DW-1:0]     result_w,
  input  logic              regwrite_m,
  input  logic [AW-1:0]     wa3_m,
  input  logic [DW-1:0]     aluresult_m,
  output logic [DW-1:0]     srca_e,
  output logic [DW-1:0]     writedata_e,
  output logic [DW-1:0]     extimm_e,
  output logic [AW-1:0]     wa3_e,
  output logic [CTRL_W-1:0] ctrl_e,
  output logic [3:0]        cond_e,
  output logic              valid_e,
  output logic              ldrstall_d
);

  logic [AW-1:0]     r_ra1_e;
  logic [AW-1:0]     r_ra2_e;
  logic [DW-1:0]     r_rd1_e;
  logic [DW-1:0]     r_rd2_e;
  logic [DW-1:0]     r_extimm_e;
  logic [AW-1:0]     r_wa3_e;
  logic [CTRL_W-1:0] r_ctrl_e;
  logic [3:0]        r_cond_e;
  logic              r_valid_e;

  logic [DW-1:0]     w_rd1_byp;
  logic [DW-1:0]     w_rd2_byp;
  fwd_t              w_sel_a;
  fwd_t              w_sel_b;

  // The regfile write lands on the same edge as our capture, so patch it in here.
  assign w_rd1_byp = (we3_w && (wa3_w == ra1_d) && (ra1_d != AW'(R15))) ? result_w : rd1_d;
  assign w_rd2_byp = (we3_w && (wa3_w == ra2_d) && (ra2_d != AW'(R15))) ? result_w : rd2_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ra1_e    <= '0;
      r_ra2_e    <= '0;
      r_rd1_e    <= '0;
      r_rd2_e    <= '0;
      r_extimm_e <= '0;
      r_wa3_e    <= '0;
      r_ctrl_e   <= '0;
      r_cond_e   <= '0;
      r_valid_e  <= 1'b0;
    end else if (flush_e) begin
      r_ra1_e    <= '0;
      r_ra2_e    <= '0;
      r_rd1_e    <= '0;
      r_rd2_e    <= '0;
      r_extimm_e <= '0;
      r_wa3_e    <= '0;
      r_ctrl_e   <= '0;
      r_cond_e   <= '0;
      r_valid_e  <= 1'b0;
    end else if (!stall_e) begin
      r_ra1_e    <= ra1_d;
      r_ra2_e    <= ra2_d;
      r_rd1_e    <= w_rd1_byp;
      r_rd2_e    <= w_rd2_byp;
      r_extimm_e <= extimm_d;
      r_wa3_e    <= wa3_d;
      r_ctrl_e   <= ctrl_d;
      r_cond_e   <= cond_d;
      r_valid_e  <= 1'b1;
    end
  end

  fwd_sel #(.AW(AW)) u_fwd_a (
    .i_ra         (r_ra1_e),
    .i_valid      (r_valid_e),
    .i_regwrite_m (regwrite_m),
    .i_wa3_m      (wa3_m),
    .i_we3_w      (we3_w),
    .i_wa3_w      (wa3_w),
    .o_sel        (w_sel_a)
  );

  fwd_sel #(.AW(AW)) u_fwd_b (
    .i_ra         (r_ra2_e),
    .i_valid      (r_valid_e),
    .i_regwrite_m (regwrite_m),
    .i_wa3_m      (wa3_m),
    .i_we3_w      (we3_w),
    .i_wa3_w      (wa3_w),
    .o_sel        (w_sel_b)
  );

  always_comb begin
    srca_e      = r_rd1_e;
    writedata_e = r_rd2_e;
    case (w_sel_a)
      FWD_M:   srca_e = aluresult_m;
      FWD_W:   srca_e = result_w;
      default: srca_e = r_rd1_e;
    endcase
    case (w_sel_b)
      FWD_M:   writedata_e = aluresult_m;
      FWD_W:   writedata_e = result_w;
      default: writedata_e = r_rd2_e;
    endcase
  end

  // A load in E whose destination is read by D cannot be forwarded in time.
  assign ldrstall_d = r_valid_e && r_ctrl_e[CTRL_MEMTOREG] && r_ctrl_e[CTRL_REGWRITE]
                      && ((r_wa3_e == ra1_d) || (r_wa3_e == ra2_d))
                      && (r_wa3_e != AW'(R15));

  assign extimm_e = r_extimm_e;
  assign wa3_e    = r_wa3_e;
  assign ctrl_e   = r_ctrl_e;
  assign cond_e   = r_cond_e;
  assign valid_e  = r_valid_e;

endmodule
